// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between the lab-counter front panel logic and the
// sequencing controller: command pulses, window setup, and count/status outputs.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 12
);
  logic             start;
  logic             stop;
  logic             step;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] count;
  logic             cnt_en;
  logic             busy;
  logic             wrap;
  logic             done;
  logic             err;

  modport master (
    output start, stop, step, mode, lo, hi,
    input  count, cnt_en, busy, wrap, done, err
  );

  modport slave (
    input  start, stop, step, mode, lo, hi,
    output count, cnt_en, busy, wrap, done, err
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the lab counter: owns the count register and
// advances it over a latched [lo, hi] window in one-shot, continuous or step mode.
module counter_seq_ctrl #(
  parameter int WIDTH    = 12,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  counter_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_cnt_en;
  logic             r_wrap;
  logic             r_done;
  logic             r_err;
  logic [PW-1:0]    r_pre;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic w_bad_start;
  logic w_tick;
  logic w_at_hi;
  logic w_cont;

  assign w_bad_start = (bus.lo > bus.hi) || (bus.mode == 2'b11);
  assign w_tick      = (r_pre == PRE_LAST);
  // Compare against hi instead of forming count+1 so the full window never overflows.
  assign w_at_hi     = (r_count == r_hi);
  assign w_cont      = (r_mode == 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_cnt_en <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_pre    <= '0;
      r_mode   <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      r_cnt_en <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_mode <= bus.mode;
            r_lo   <= bus.lo;
            r_hi   <= bus.hi;
            if (w_bad_start) begin
              r_err <= 1'b1;
            end else begin
              r_count  <= bus.lo;
              r_pre    <= '0;
              r_cnt_en <= 1'b1;
              r_state  <= (bus.mode == 2'b10) ? S_PAUSE : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else begin
            r_pre <= w_tick ? '0 : r_pre + PW'(1);
            if (w_tick) begin
              if (!w_at_hi) begin
                r_count  <= r_count + WIDTH'(1);
                r_cnt_en <= 1'b1;
              end else if (w_cont) begin
                r_count  <= r_lo;
                r_wrap   <= 1'b1;
                r_cnt_en <= 1'b1;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_PAUSE: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else if (bus.step) begin
            r_cnt_en <= 1'b1;
            if (!w_at_hi) begin
              r_count <= r_count + WIDTH'(1);
            end else begin
              r_count <= r_lo;
              r_wrap  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.count  = r_count;
  assign bus.cnt_en = r_cnt_en;
  assign bus.busy   = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.wrap   = r_wrap;
  assign bus.done   = r_done;
  assign bus.err    = r_err;

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the 12-bit lab counter datapath. It owns the count register and decides when the count advances: free-run, single sweep, or manual step. Sweeps cover a programmable window [lo, hi] with an optional clock prescaler. It sits between the top-level switch/button logic and the consumers of the count, such as the display and ROM address.

Parameters:
WIDTH, 12, count and window bound width
PRESCALE, 1, clocks per count tick in run modes; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  single-cycle pulse; latches mode/lo/hi and begins a sequence
stop  input  1  single-cycle pulse; aborts the sequence, count holds
step  input  1  single-cycle pulse; advances one count in step mode
mode  input  2  00 one-shot sweep, 01 continuous, 10 step, 11 reserved
lo  input  WIDTH  window start (inclusive)
hi  input  WIDTH  window end (inclusive)
count  output  WIDTH  current count
cnt_en  output  1  high for exactly the cycles in which count changed on that edge
busy  output  1  high in RUN or PAUSE
wrap  output  1  1-cycle pulse when count reloads hi -> lo
done  output  1  1-cycle pulse when a one-shot sweep reaches its end
err  output  1  1-cycle pulse when start is rejected

Behaviour:
- All outputs are registered and update only on the rising clk edge.
- Reset (rst=1 at an edge), including mid-sequence: state IDLE; count=0; cnt_en, busy, wrap, done and err all 0; prescaler=0; latched mode/lo/hi=0.
- States are IDLE, RUN, PAUSE and DONE.
- IDLE/DONE with start:
  - Inputs are latched on that edge.
  - If lo>hi or mode=11: err=1 for one cycle, state unchanged, count unchanged.
  - Otherwise count<=lo, prescaler<=0, busy=1 from the next cycle, and cnt_en=1 in that cycle.
  - Next state is RUN for mode 00/01 and PAUSE for mode 10.
- start while busy is ignored. lo, hi and mode changes during a sequence have no effect.
- RUN:
  - The prescaler counts 0..PRESCALE-1; a tick occurs when prescaler==PRESCALE-1, then the prescaler wraps to 0. With PRESCALE=1 every cycle is a tick.
  - First tick: the first increment occurs PRESCALE cycles after the start edge.
  - Tick with count<hi: count<=count+1, cnt_en=1.
  - Tick with count==hi, continuous mode: count<=lo, wrap=1, cnt_en=1.
  - Tick with count==hi, one-shot mode: count holds hi, done=1, cnt_en=0, state DONE, busy=0.
- PAUSE (step mode):
  - The prescaler is idle.
  - step advances exactly as a RUN tick in continuous mode: increment, or wrap hi->lo with a wrap pulse.
  - step asserted for k consecutive cycles gives k advances.
- lo==hi: every tick reloads lo with a wrap pulse (continuous) or ends immediately with done (one-shot); count stays constant.
- Full window lo=0, hi=2^WIDTH-1: hi+1 is never formed; wrap is by reload only, never arithmetic overflow.
- stop in RUN/PAUSE: state IDLE, busy=0, count holds its current value, no wrap/done/cnt_en pulse.
- stop is a no-op in IDLE/DONE.
- Priority on the same edge: rst > stop > start > tick/step. stop and a terminal tick together give no done and no wrap.
- DONE behaves as IDLE except that it is reached via done. count stays at hi until the next start.
- wrap, done and err are never high in the same cycle.

Test Plan:
- Reset mid-RUN (count=37) -> next cycle count=0, busy=0, cnt_en=0, state IDLE; a following start is accepted.
- Continuous, lo=0, hi=4095, PRESCALE=1, start at cycle 0 -> count=0 at cycle 1, 4095 at cycle 4096, 0 with wrap=1 at cycle 4097; exactly 2 wrap pulses by cycle 8193.
- One-shot, lo=10, hi=13, PRESCALE=3 -> count 10,11,12,13 changing every 3 cycles; done pulses once 3 cycles after reaching 13; count stays 13; busy=0.
- Step mode, lo=5, hi=6: step x3 -> count 6, 5 (wrap=1), 6; no change without step over 20 idle cycles.
- start with lo=9, hi=3, then with mode=11 -> err pulses twice; count and state unchanged. start while busy -> no effect.
- stop and a terminal tick on the same edge (one-shot) -> IDLE, count=hi, done=0, wrap=0. lo==hi=7 continuous -> count fixed at 7, wrap every tick.
